mac_scheduler: RTL and testbench



---
 rtl/mac_sched_pkg.sv | 21 ++
 rtl/mac_scheduler_rr_arbiter.sv | 40 ++++
 rtl/mac_scheduler.sv | 107 ++++++++++
 tb/tb_mac_scheduler.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared constants and types for the MAC scheduler.
//   A_W, B_W, C_W : operand A / operand B / addend-and-result widths
//   MAC_LAT       : MAC pipeline depth in ce-qualified cycles
//   tag_t         : {valid, id} carried alongside each MAC operation
package mac_sched_pkg;

    localparam int A_W      = 27;
    localparam int B_W      = 18;
    localparam int C_W      = 48;
    localparam int MAC_LAT  = 3;

    // Sized for the largest supported requester count (16). Smaller
    // configurations use only the low bits of id.
    localparam int TAG_ID_W = 4;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin picker. Searches from ptr+1 (mod NREQ) and grants
// the first asserted request.
//   req       in  NREQ  request vector
//   en        in  1     arbitration enable; no grant when low
//   ptr       in  ID_W  last granted index
//   grant     out NREQ  one-hot grant, or zero
//   grant_id  out ID_W  index of the granted requester
//   any_grant out 1     a grant was issued
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = 0;
        if (en) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(ptr) + k) % NREQ;
                if (!any_grant && req[idx]) begin
                    grant[idx] = 1'b1;
                    grant_id   = ID_W'(idx);
                    any_grant  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mac_scheduler.sv
// mac_scheduler: shares one pipelined, ce-gated a*b+c MAC among NREQ
// requesters. One round-robin grant per cycle; requester IDs ride a tag
// pipeline matched to the MAC latency and come back with the result on a
// valid/ready response port. Response back-pressure freezes the MAC and the
// tag pipeline together through mac_ce.
//   clk, rst             clock; synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready one-hot or zero)
//   req_a/req_b/req_c    packed operands, requester i in slice i
//   mac_ce, mac_a/b/c    MAC clock enable and inputs
//   mac_p                MAC result
//   rsp_valid/rsp_ready  response handshake; rsp_id, rsp_data payload
//   busy                 at least one operation in flight
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    input  logic [NREQ*C_W-1:0] req_c,
    output logic                mac_ce,
    output logic [A_W-1:0]      mac_a,
    output logic [B_W-1:0]      mac_b,
    output logic [C_W-1:0]      mac_c,
    input  logic [C_W-1:0]      mac_p,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [C_W-1:0]      rsp_data,
    output logic                busy
);

    tag_t                tag_q [MAC_LAT];
    tag_t                tag_in;
    logic [ID_W-1:0]     rr_ptr;
    logic [NREQ-1:0]     grant;
    logic [ID_W-1:0]     grant_id;
    logic                any_grant;
    logic                stall;

    assign rsp_valid = tag_q[MAC_LAT-1].valid;
    assign rsp_id    = tag_q[MAC_LAT-1].id[ID_W-1:0];
    assign rsp_data  = mac_p;

    // A held response stalls everything upstream, MAC included.
    assign stall     = rsp_valid & ~rsp_ready;
    assign mac_ce    = ~stall;
    assign req_ready = grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .en        (mac_ce),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    // Operands are zero when nothing is granted so idle cycles push a clean
    // bubble into the MAC.
    always_comb begin
        mac_a = '0;
        mac_b = '0;
        mac_c = '0;
        if (any_grant) begin
            mac_a = req_a[int'(grant_id)*A_W +: A_W];
            mac_b = req_b[int'(grant_id)*B_W +: B_W];
            mac_c = req_c[int'(grant_id)*C_W +: C_W];
        end
    end

    always_comb begin
        tag_in                = '0;
        tag_in.valid          = any_grant;
        tag_in.id[ID_W-1:0]   = grant_id;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < MAC_LAT; s++) begin
                tag_q[s] <= '0;
            end
            rr_ptr <= ID_W'(NREQ - 1);
        end else if (mac_ce) begin
            tag_q[0] <= tag_in;
            for (int s = 1; s < MAC_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            if (any_grant) begin
                rr_ptr <= grant_id;
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < MAC_LAT; s++) begin
            busy = busy | tag_q[s].valid;
        end
    end

endmodule

// File: tb/tb_mac_scheduler.sv
module tb_mac_scheduler;
    import mac_sched_pkg::*;

    localparam int NREQ = 4;
    localparam int ID_W = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*A_W-1:0] req_a;
    logic [NREQ*B_W-1:0] req_b;
    logic [NREQ*C_W-1:0] req_c;
    logic                mac_ce;
    logic [A_W-1:0]      mac_a;
    logic [B_W-1:0]      mac_b;
    logic [C_W-1:0]      mac_c;
    logic [C_W-1:0]      mac_p;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [C_W-1:0]      rsp_data;
    logic                busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_scheduler #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .mac_ce    (mac_ce),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_c     (mac_c),
        .mac_p     (mac_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Three-stage ce-gated MAC, no reset.
    logic signed [C_W-1:0] ea, eb;
    logic        [C_W-1:0] m0, m1, m2;
    assign ea    = C_W'($signed(mac_a));
    assign eb    = C_W'($signed(mac_b));
    assign mac_p = m2;
    always_ff @(posedge clk) begin
        if (mac_ce) begin
            m0 <= C_W'(ea * eb) + mac_c;
            m1 <= m0;
            m2 <= m1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                          input logic [C_W-1:0] c);
        req_a[i*A_W +: A_W] = a;
        req_b[i*B_W +: B_W] = b;
        req_c[i*C_W +: C_W] = c;
    endtask

    // Leaves the bench on a falling edge with rst low, ready to drive cycle 0.
    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [C_W-1:0] exp_d;
    int             nxt;
    int             eop;
    logic           exp_stall;
    logic           exp_grant;

    initial begin
        req_a = '0;
        req_b = '0;
        req_c = '0;
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_busy",      64'(busy),      64'd0);
        check_eq("rst_mac_ce",    64'(mac_ce),    64'd1);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_mac_a",     64'(mac_a),     64'd0);

        // Single op: requester 1, 3*5+7 = 22
        set_op(1, A_W'(3), B_W'(5), C_W'(7));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b0010 : 4'b0000;
            #1;
            check_eq("single_ready", 64'(req_ready), (c == 0) ? 64'd2 : 64'd0);
            check_eq("single_rsp_valid", 64'(rsp_valid), (c == 3) ? 64'd1 : 64'd0);
            check_eq("single_busy", 64'(busy), (c >= 1 && c <= 3) ? 64'd1 : 64'd0);
            if (c == 0) check_eq("single_mac_a", 64'(mac_a), 64'd3);
            if (c == 3) begin
                check_eq("single_id",   64'(rsp_id),   64'd1);
                check_eq("single_data", 64'(rsp_data), 64'd22);
            end
        end

        // Signed: requester 0, -2*4+1 = -7
        set_op(0, A_W'(-2), B_W'(4), C_W'(1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            #1;
            if (c == 0) check_eq("signed_ready", 64'(req_ready), 64'd1);
            check_eq("signed_rsp_valid", 64'(rsp_valid), (c == 3) ? 64'd1 : 64'd0);
            if (c == 3) begin
                check_eq("signed_id",   64'(rsp_id),   64'd0);
                check_eq("signed_data", 64'(rsp_data), 64'h0000_FFFF_FFFF_FFF9);
            end
        end

        // Round-robin: all four requesting for 8 cycles
        @(negedge clk);
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, A_W'(i + 1), B_W'(1), C_W'(0));
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            check_eq("rr_ready", 64'(req_ready), (k < 8) ? 64'(1 << (k % 4)) : 64'd0);
            check_eq("rr_rsp_valid", 64'(rsp_valid), (k >= 3 && k < 11) ? 64'd1 : 64'd0);
            if (k >= 3 && k < 11) begin
                check_eq("rr_id",   64'(rsp_id),   64'((k - 3) % 4));
                check_eq("rr_data", 64'(rsp_data), 64'((k - 3) % 4 + 1));
            end
        end

        // Back-pressure: requester 2 streams op n = (a=n, b=3, c=100);
        // response held in cycles 3 and 4.
        @(negedge clk);
        do_reset();
        nxt = 1;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            set_op(2, A_W'(nxt), B_W'(3), C_W'(100));
            req_valid = (nxt <= 6) ? 4'b0100 : 4'b0000;
            rsp_ready = !(c == 3 || c == 4);
            exp_stall = (c == 3 || c == 4);
            exp_grant = !exp_stall && (nxt <= 6);
            eop = (c >= 3 && c <= 5) ? 1 : ((c >= 6 && c <= 10) ? c - 4 : 0);
            #1;
            check_eq("bp_mac_ce", 64'(mac_ce), exp_stall ? 64'd0 : 64'd1);
            check_eq("bp_ready", 64'(req_ready), exp_grant ? 64'd4 : 64'd0);
            check_eq("bp_rsp_valid", 64'(rsp_valid), (eop != 0) ? 64'd1 : 64'd0);
            if (eop != 0) begin
                check_eq("bp_id",   64'(rsp_id),   64'd2);
                check_eq("bp_data", 64'(rsp_data), 64'(3 * eop + 100));
            end
            if (c == 11) check_eq("bp_busy_end", 64'(busy), 64'd0);
            if (exp_grant) nxt++;
        end
        rsp_ready = 1'b1;

        // Mid-flight reset: three ops, reset in cycle 2, then new traffic.
        for (int i = 0; i < NREQ; i++) set_op(i, A_W'(i + 1), B_W'(1), C_W'(0));
        set_op(3, A_W'(6), B_W'(7), C_W'(-1));
        set_op(0, A_W'(2), B_W'(2), C_W'(2));
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            rst       = (c == 2);
            req_valid = (c <= 2 || c == 4) ? 4'b1111 : ((c == 3) ? 4'b1000 : 4'b0000);
            #1;
            check_eq("mr_rsp_valid", 64'(rsp_valid), (c == 6 || c == 7) ? 64'd1 : 64'd0);
            if (c == 3) begin
                check_eq("mr_busy_cleared", 64'(busy), 64'd0);
                check_eq("mr_ready3", 64'(req_ready), 64'd8);
            end
            if (c == 4) check_eq("mr_contention", 64'(req_ready), 64'd1);
            if (c == 6) begin
                check_eq("mr_id3",   64'(rsp_id),   64'd3);
                check_eq("mr_data3", 64'(rsp_data), 64'd41);
            end
            if (c == 7) begin
                check_eq("mr_id0",   64'(rsp_id),   64'd0);
                check_eq("mr_data0", 64'(rsp_data), 64'd6);
            end
        end

        // Idle bubbles: requester 1 every third cycle, op k = (a=k+2, b=-3, c=5)
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            exp_grant = (c % 3 == 0) && (c <= 6);
            set_op(1, A_W'(c / 3 + 2), B_W'(-3), C_W'(5));
            req_valid = exp_grant ? 4'b0010 : 4'b0000;
            #1;
            check_eq("idle_ready", 64'(req_ready), exp_grant ? 64'd2 : 64'd0);
            check_eq("idle_mac_a", 64'(mac_a), exp_grant ? 64'(c / 3 + 2) : 64'd0);
            if (!exp_grant) begin
                check_eq("idle_mac_b", 64'(mac_b), 64'd0);
                check_eq("idle_mac_c", 64'(mac_c), 64'd0);
            end
            check_eq("idle_rsp_valid", 64'(rsp_valid),
                     (c == 3 || c == 6 || c == 9) ? 64'd1 : 64'd0);
            if (c == 3 || c == 6 || c == 9) begin
                case (c)
                    3:       exp_d = C_W'(-1);
                    6:       exp_d = C_W'(-4);
                    default: exp_d = C_W'(-7);
                endcase
                check_eq("idle_id",   64'(rsp_id),   64'd1);
                check_eq("idle_data", 64'(rsp_data), 64'(exp_d));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
